// File: rtl/matvec_seq_if.sv
// Operand/result bus between the layer sequencer (master) and matvec_seq (slave).
interface matvec_seq_if #(
    parameter int N = 32,
    parameter int W = 16
);
    logic                         start;
    logic [W-1:0][W-1:0][N-1:0]   mat1;
    logic [W-1:0][N-1:0]          mat2;
    logic [W-1:0][N-1:0]          bias;
    logic [W-1:0][N-1:0]          out;
    logic                         flag;
    logic                         done;

    modport master (output start, mat1, mat2, bias, input out, flag, done);
    modport slave  (input start, mat1, mat2, bias, output out, flag, done);
endinterface

// File: rtl/matvec_seq.sv
// Sequential matrix-vector multiply-accumulate: one signed multiplier,
// one mat1 element per cycle, W*W cycles per job.
// out[r] = sat((sum_c mat1[r][c]*mat2[c] + (bias[r]<<FRAC)) >>> FRAC)
// Optional macro MATVEC_RELU_EN: negative results are written back as 0.
module matvec_seq #(
    parameter int N    = 32,
    parameter int W    = 16,
    parameter int FRAC = 0
) (
    input  logic         clk,
    input  logic         rst,
    matvec_seq_if.slave  bus
);
    localparam int AW = 2*N + $clog2(W) + 1;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                       state, state_nx;
    logic [W-1:0][W-1:0][N-1:0]   snap1;
    logic [W-1:0][N-1:0]          snap2, snapb, res, out_q;
    logic [CW-1:0]                r, c, nb_idx;
    logic signed [AW-1:0]         acc, acc_sum, shifted;
    logic signed [2*N-1:0]        prod;
    logic [N-1:0]                 wb_val;
    logic                         last_col, last_row;

    localparam logic signed [AW-1:0] SMAX = AW'({1'b0, {(N-1){1'b1}}});
    localparam logic signed [AW-1:0] SMIN = -SMAX - 1;

    // Bias aligned to the accumulator's fixed-point position.
    function automatic logic signed [AW-1:0] bias_ext(input logic [N-1:0] b);
        logic signed [AW-1:0] t;
        t = {{(AW-N){b[N-1]}}, b};
        return t <<< FRAC;
    endfunction

    assign last_col = (c == CW'(W-1));
    assign last_row = (r == CW'(W-1));
    assign nb_idx   = last_row ? '0 : r + 1'b1;

    // MAC datapath and writeback value for the current row.
    always_comb begin
        prod    = signed'(snap1[r][c]) * signed'(snap2[c]);
        acc_sum = acc + AW'(prod);
        shifted = acc_sum >>> FRAC;
        if (shifted > SMAX)
            wb_val = {1'b0, {(N-1){1'b1}}};
        else if (shifted < SMIN)
            wb_val = {1'b1, {(N-1){1'b0}}};
        else
            wb_val = shifted[N-1:0];
`ifdef MATVEC_RELU_EN
        if (wb_val[N-1])
            wb_val = '0;
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next state; start is only looked at in IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (last_col && last_row) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Snapshot, accumulate, per-row result capture and final out update.
    // out is loaded on the last MAC step so it is valid during the DONE cycle,
    // the same cycle flag falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap1 <= '0;
            snap2 <= '0;
            snapb <= '0;
            res   <= '0;
            out_q <= '0;
            acc   <= '0;
            r     <= '0;
            c     <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    snap1 <= bus.mat1;
                    snap2 <= bus.mat2;
                    snapb <= bus.bias;
                    acc   <= bias_ext(bus.bias[0]);
                    r     <= '0;
                    c     <= '0;
                end
                RUN: begin
                    if (!last_col) begin
                        acc <= acc_sum;
                        c   <= c + 1'b1;
                    end else begin
                        res[r] <= wb_val;
                        acc    <= bias_ext(snapb[nb_idx]);
                        c      <= '0;
                        r      <= nb_idx;
                        if (last_row) begin
                            out_q        <= res;
                            out_q[W-1]   <= wb_val;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out  = out_q;
    assign bus.flag = (state == RUN);
    assign bus.done = (state == DONE);
endmodule

// File: tb/tb_matvec_seq.sv
// Directed bench for matvec_seq: table of full jobs plus hand sequences for
// mid-job input changes, reset during RUN and a held start.
module tb_matvec_seq;
    localparam int N = 32;
    localparam int W = 16;

    typedef struct {
        logic [W-1:0][W-1:0][N-1:0] m1;
        logic [W-1:0][N-1:0]        m2;
        logic [W-1:0][N-1:0]        b;
        logic [W-1:0][N-1:0]        exp;
    } vec_t;

    logic clk = 0;
    logic rst;
    int   cmp = 0;
    int   bad = 0;
    vec_t vecs[5];

    matvec_seq_if #(.N(N), .W(W)) bus();
    matvec_seq #(.N(N), .W(W), .FRAC(0)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string nm, input longint got, input longint exp);
        cmp++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [N-1:0] relu(input logic [N-1:0] x);
`ifdef MATVEC_RELU_EN
        return x[N-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    // Plain dot product in wide integer arithmetic, then clamp.
    function automatic logic [N-1:0] ref_row(input vec_t v, input int r);
        logic signed [95:0] s;
        s = 96'(signed'(v.b[r]));
        for (int k = 0; k < W; k++)
            s = s + 96'(signed'(v.m1[r][k])) * 96'(signed'(v.m2[k]));
        if (s > 96'sh7FFFFFFF)       return relu(32'h7FFFFFFF);
        if (s < -96'sh80000000)      return relu(32'h80000000);
        return relu(s[N-1:0]);
    endfunction

    task automatic load(input int vi);
        bus.mat1 = vecs[vi].m1;
        bus.mat2 = vecs[vi].m2;
        bus.bias = vecs[vi].b;
    endtask

    // Run one job; chg_at>0 changes mat2 and pulses start at that RUN cycle.
    task automatic run_job(input int vi, input int chg_at, output int lat,
                           output int fcnt, output int dcnt, output bit stable);
        logic [W-1:0][N-1:0] prev;
        int i;
        lat = -1; fcnt = 0; dcnt = 0; stable = 1;
        @(negedge clk);
        prev = bus.out;
        load(vi);
        bus.start = 1;
        @(posedge clk);
        i = 0;
        while (lat < 0 && i < 1000) begin
            @(negedge clk);
            i++;
            bus.start = 0;
            if (bus.flag) fcnt++;
            if (bus.done) begin lat = i; dcnt++; end
            else if (bus.out != prev) stable = 0;
            if (i == chg_at) begin
                bus.mat2  = '{default: 32'd99};
                bus.start = 1;
            end
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
    endtask

    task automatic check_rows(input string nm, input logic [W-1:0][N-1:0] exp);
        for (int r = 0; r < W; r++)
            check($sformatf("%s_row%0d", nm, r), longint'(bus.out[r]), longint'(exp[r]));
    endtask

    initial begin
        int lat, fcnt, dcnt, n;
        bit stable;

        // Table: identity, column-0, +sat, -sat, mixed.
        for (int v = 0; v < 5; v++) begin
            vecs[v].m1 = '0; vecs[v].m2 = '0; vecs[v].b = '0; vecs[v].exp = '0;
        end
        for (int i = 0; i < W; i++) begin
            vecs[0].m1[i][i] = 32'd1;
            vecs[0].m2[i]    = 32'(i);
            vecs[0].exp[i]   = 32'(i);
            vecs[1].m2[i]    = 32'(i + 3);
            vecs[1].m1[i][0] = 32'(i * 10 - 70);
            vecs[1].b[i]     = 32'(i);
            vecs[1].exp[i]   = relu(32'(51 * i - 350));
            vecs[2].m2[i]    = 32'h7FFFFFFF;
            vecs[2].exp[i]   = 32'h7FFFFFFF;
            vecs[3].m2[i]    = 32'h80000001;
            vecs[3].exp[i]   = relu(32'h80000000);
            vecs[4].m2[i]    = 32'(i - 5);
            vecs[4].b[i]     = 32'(i * 100 - 800);
            for (int j = 0; j < W; j++) begin
                vecs[2].m1[i][j] = 32'h7FFFFFFF;
                vecs[3].m1[i][j] = 32'h7FFFFFFF;
                vecs[4].m1[i][j] = 32'(i * 3 - j * 7);
            end
        end
        vecs[1].m2[0]    = 32'd5;
        vecs[1].m1[0][0] = -32'sd325;
        vecs[1].m1[1][0] = 32'd1565;
        vecs[1].b[0]     = 32'd713;
        vecs[1].b[1]     = 32'd1306;
        vecs[1].exp[0]   = relu(-32'sd912);
        vecs[1].exp[1]   = 32'd9131;
        for (int i = 0; i < W; i++) vecs[4].exp[i] = ref_row(vecs[4], i);

        // Reset state.
        rst = 0; bus.start = 0; bus.mat1 = '0; bus.mat2 = '0; bus.bias = '0;
        repeat (3) @(negedge clk);
        check("rst_out_zero", longint'(bus.out == '0), 1);
        check("rst_flag", longint'(bus.flag), 0);
        check("rst_done", longint'(bus.done), 0);
        rst = 1;

        for (int v = 0; v < 5; v++) begin
            run_job(v, 0, lat, fcnt, dcnt, stable);
            check($sformatf("v%0d_latency", v), lat, W*W + 1);
            check($sformatf("v%0d_flag_cycles", v), fcnt, W*W);
            check($sformatf("v%0d_done_pulses", v), dcnt, 1);
            check($sformatf("v%0d_out_held", v), longint'(stable), 1);
            check_rows($sformatf("v%0d", v), vecs[v].exp);
        end

        // Mid-job mat2 change and start pulse: no restart, original snapshot used.
        run_job(0, 100, lat, fcnt, dcnt, stable);
        check("mid_latency", lat, W*W + 1);
        check("mid_done_pulses", dcnt, 1);
        check("mid_flag_cycles", fcnt, W*W);
        check_rows("mid", vecs[0].exp);

        // Reset at RUN cycle 80: out, flag, done clear without a clock edge.
        @(negedge clk);
        load(1);
        bus.start = 1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 0;
        repeat (79) @(negedge clk);
        check("abort_flag_before", longint'(bus.flag), 1);
        #2 rst = 0;
        #1;
        check("abort_out_zero", longint'(bus.out == '0), 1);
        check("abort_flag", longint'(bus.flag), 0);
        check("abort_done", longint'(bus.done), 0);
        repeat (2) @(negedge clk);
        rst = 1;
        run_job(4, 0, lat, fcnt, dcnt, stable);
        check("post_rst_latency", lat, W*W + 1);
        check("post_rst_flag_cycles", fcnt, W*W);
        check_rows("post_rst", vecs[4].exp);

        // Held start: IDLE for one cycle after DONE, then re-accepted.
        @(negedge clk);
        load(0);
        bus.start = 1;
        n = 0;
        while (!bus.done && n < 1000) begin @(negedge clk); n++; end
        check("held_first_done", longint'(bus.done), 1);
        @(negedge clk);
        check("held_idle_gap_flag", longint'(bus.flag), 0);
        @(negedge clk);
        check("held_restart_flag", longint'(bus.flag), 1);
        bus.start = 0;
        n = 0;
        while (!bus.done && n < 1000) begin @(negedge clk); n++; end
        check("held_second_done", longint'(bus.done), 1);
        check_rows("held", vecs[0].exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
